multicycle_sequencer: RTL and testbench

Multi-cycle control FSM that sequences the shared processor datapath: one ALU, one unified memory port, the register file, and the PC/IR/ALUOut registers. It walks each instruction through FETCH, DECODE, EXEC, MEM and WB, and issues per-state mux selects and write strobes. It handshakes with a variable-latency memory, halts with a sticky fault on an illegal opcode or a memory timeout, and honours an external stall at instruction boundaries.

---
 rtl/multicycle_sequencer.sv | 327 ++++++++++++++++++++++++++++++++
 tb/tb_multicycle_sequencer.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer
//   Control FSM for a shared multi-cycle datapath (one ALU, one unified
//   memory port, register file, PC/IR/ALUOut). Each instruction walks
//   FETCH -> DECODE -> EXEC -> MEM -> WB as its class requires. Memory
//   handshakes through MemReady with a bounded wait. Illegal opcodes and
//   memory timeouts park the FSM in HALT with a sticky Fault.
//
// Ports
//   CLK, Reset_L             clock, async active-low reset
//   Opcode, FuncCode         IR[31:26], IR[5:0]
//   Zero                     ALU zero flag (branch resolution)
//   MemReady                 memory completes the current request this cycle
//   Stall                    hold at the next instruction boundary (FETCH only)
//   PCWrite .. SignExtend    datapath strobes and selects
//   ALUSrcA/ALUSrcB/ALUOp    ALU operand selects and operation
//   PCSource                 next-PC source
//   State                    FETCH 0, DECODE 1, EXEC 2, MEM 3, WB 4, HALT 7
//   InstrDone                pulse in the last cycle of each instruction
//   Fault                    sticky fault flag
//
// Outputs are a decode of the registered state and latched opcode class,
// qualified by MemReady/Zero/Stall where needed, and forced to 0 while
// Reset_L is low.
module multicycle_sequencer #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic       CLK,
  input  logic       Reset_L,
  input  logic [5:0] Opcode,
  input  logic [5:0] FuncCode,
  input  logic       Zero,
  input  logic       MemReady,
  input  logic       Stall,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IorD,
  output logic       RegDst,
  output logic       MemToReg,
  output logic       SignExtend,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [3:0] ALUOp,
  output logic [1:0] PCSource,
  output logic [2:0] State,
  output logic       InstrDone,
  output logic       Fault
);

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd7
  } state_t;

  typedef enum logic [3:0] {
    CL_R     = 4'd0,
    CL_LW    = 4'd1,
    CL_SW    = 4'd2,
    CL_BEQ   = 4'd3,
    CL_J     = 4'd4,
    CL_ADDI  = 4'd5,
    CL_ADDIU = 4'd6,
    CL_SLTI  = 4'd7,
    CL_SLTIU = 4'd8,
    CL_ANDI  = 4'd9,
    CL_ORI   = 4'd10,
    CL_XORI  = 4'd11,
    CL_LUI   = 4'd12,
    CL_ILL   = 4'd15
  } class_t;

  localparam logic [5:0] OP_R     = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_XORI  = 6'b001110;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_SLT   = 4'b0111;
  localparam logic [3:0] ALU_ADDU  = 4'b1000;
  localparam logic [3:0] ALU_XOR   = 4'b1010;
  localparam logic [3:0] ALU_SLTU  = 4'b1011;
  localparam logic [3:0] ALU_LUI   = 4'b1110;
  localparam logic [3:0] ALU_FUNCT = 4'b1111;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  // Map a raw opcode onto its instruction class; anything unlisted is illegal.
  function automatic class_t classify(input logic [5:0] op);
    case (op)
      OP_R:     classify = CL_R;
      OP_LW:    classify = CL_LW;
      OP_SW:    classify = CL_SW;
      OP_BEQ:   classify = CL_BEQ;
      OP_J:     classify = CL_J;
      OP_ADDI:  classify = CL_ADDI;
      OP_ADDIU: classify = CL_ADDIU;
      OP_SLTI:  classify = CL_SLTI;
      OP_SLTIU: classify = CL_SLTIU;
      OP_ANDI:  classify = CL_ANDI;
      OP_ORI:   classify = CL_ORI;
      OP_XORI:  classify = CL_XORI;
      OP_LUI:   classify = CL_LUI;
      default:  classify = CL_ILL;
    endcase
  endfunction

  state_t     state_r;
  state_t     state_nxt;
  class_t     class_r;
  class_t     dec_class_s;
  logic [7:0] wait_cnt_r;
  logic       fault_r;

  logic       mem_req_s;
  logic       timeout_s;
  logic       shift_s;

  logic       pc_write_s, ir_write_s, reg_write_s, mem_read_s, mem_write_s;
  logic       iord_s, reg_dst_s, mem_to_reg_s, sign_ext_s, instr_done_s;
  logic [1:0] alu_src_a_s, alu_src_b_s, pc_source_s;
  logic [3:0] alu_op_s;

  assign dec_class_s = classify(Opcode);
  assign timeout_s   = (wait_cnt_r == TIMEOUT_CNT);
  // Shift instructions take their A operand from the shamt field.
  assign shift_s     = (FuncCode == 6'b000000) || (FuncCode == 6'b000010) ||
                       (FuncCode == 6'b000011);

  // Next-state and per-state control decode.
  always_comb begin
    state_nxt    = state_r;
    mem_req_s    = 1'b0;
    pc_write_s   = 1'b0;
    ir_write_s   = 1'b0;
    reg_write_s  = 1'b0;
    mem_read_s   = 1'b0;
    mem_write_s  = 1'b0;
    iord_s       = 1'b0;
    reg_dst_s    = 1'b0;
    mem_to_reg_s = 1'b0;
    sign_ext_s   = 1'b0;
    instr_done_s = 1'b0;
    alu_src_a_s  = 2'd0;
    alu_src_b_s  = 2'd0;
    pc_source_s  = 2'd0;
    alu_op_s     = ALU_AND;
    case (state_r)
      ST_FETCH: begin
        // A nonzero wait count means the fetch was already issued, so a
        // late Stall must not withdraw it.
        if (!Stall || (wait_cnt_r != 8'd0)) begin
          mem_req_s   = 1'b1;
          mem_read_s  = 1'b1;
          alu_src_b_s = 2'd1;
          alu_op_s    = ALU_ADD;
          if (MemReady) begin
            ir_write_s = 1'b1;
            pc_write_s = 1'b1;
            state_nxt  = ST_DECODE;
          end else if (timeout_s) begin
            state_nxt = ST_HALT;
          end else begin
            state_nxt = ST_FETCH;
          end
        end else begin
          state_nxt = ST_FETCH;
        end
      end
      ST_DECODE: begin
        // Branch target PC + (imm<<2) is computed here into ALUOut.
        alu_src_b_s = 2'd3;
        alu_op_s    = ALU_ADD;
        sign_ext_s  = 1'b1;
        case (dec_class_s)
          CL_J: begin
            pc_write_s   = 1'b1;
            pc_source_s  = 2'd2;
            instr_done_s = 1'b1;
            state_nxt    = ST_FETCH;
          end
          CL_ILL:  state_nxt = ST_HALT;
          default: state_nxt = ST_EXEC;
        endcase
      end
      ST_EXEC: begin
        alu_src_a_s = 2'd1;
        alu_src_b_s = 2'd2;
        state_nxt   = ST_WB;
        case (class_r)
          CL_R: begin
            alu_src_a_s = shift_s ? 2'd2 : 2'd1;
            alu_src_b_s = 2'd0;
            alu_op_s    = ALU_FUNCT;
          end
          CL_ADDI:  begin alu_op_s = ALU_ADD;  sign_ext_s = 1'b1; end
          CL_ADDIU: begin alu_op_s = ALU_ADDU; sign_ext_s = 1'b1; end
          CL_SLTI:  begin alu_op_s = ALU_SLT;  sign_ext_s = 1'b1; end
          CL_SLTIU: begin alu_op_s = ALU_SLTU; sign_ext_s = 1'b1; end
          CL_ANDI:  alu_op_s = ALU_AND;
          CL_ORI:   alu_op_s = ALU_OR;
          CL_XORI:  alu_op_s = ALU_XOR;
          CL_LUI:   alu_op_s = ALU_LUI;
          CL_LW, CL_SW: begin
            alu_op_s   = ALU_ADD;
            sign_ext_s = 1'b1;
            state_nxt  = ST_MEM;
          end
          CL_BEQ: begin
            // rs XOR rt drives Zero; the target is already in ALUOut.
            alu_src_b_s  = 2'd0;
            alu_op_s     = ALU_XOR;
            pc_source_s  = 2'd1;
            pc_write_s   = Zero;
            instr_done_s = 1'b1;
            state_nxt    = ST_FETCH;
          end
          default: state_nxt = ST_HALT;
        endcase
      end
      ST_MEM: begin
        iord_s    = 1'b1;
        mem_req_s = 1'b1;
        case (class_r)
          CL_LW: begin
            mem_read_s = 1'b1;
            if (MemReady) begin
              state_nxt = ST_WB;
            end else if (timeout_s) begin
              state_nxt = ST_HALT;
            end else begin
              state_nxt = ST_MEM;
            end
          end
          CL_SW: begin
            mem_write_s = 1'b1;
            if (MemReady) begin
              instr_done_s = 1'b1;
              state_nxt    = ST_FETCH;
            end else if (timeout_s) begin
              state_nxt = ST_HALT;
            end else begin
              state_nxt = ST_MEM;
            end
          end
          default: begin
            mem_req_s = 1'b0;
            state_nxt = ST_HALT;
          end
        endcase
      end
      ST_WB: begin
        reg_write_s  = 1'b1;
        instr_done_s = 1'b1;
        reg_dst_s    = (class_r == CL_R);
        mem_to_reg_s = (class_r == CL_LW);
        state_nxt    = ST_FETCH;
      end
      ST_HALT:  state_nxt = ST_HALT;
      default:  state_nxt = ST_HALT;
    endcase
  end

  // FSM state, opcode class, memory wait counter and sticky fault.
  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      state_r    <= ST_FETCH;
      class_r    <= CL_R;
      wait_cnt_r <= 8'd0;
      fault_r    <= 1'b0;
    end else begin
      state_r <= state_nxt;
      if (state_r == ST_DECODE) begin
        class_r <= dec_class_s;
      end else begin
        class_r <= class_r;
      end
      // Counts consecutive unanswered request cycles; any other cycle clears
      // it, so it starts from zero on every entry to FETCH or MEM.
      if (mem_req_s && !MemReady) begin
        wait_cnt_r <= wait_cnt_r + 8'd1;
      end else begin
        wait_cnt_r <= 8'd0;
      end
      if (state_nxt == ST_HALT) begin
        fault_r <= 1'b1;
      end else begin
        fault_r <= fault_r;
      end
    end
  end

  // Reset_L gating keeps every control output quiet the instant reset falls.
  assign PCWrite    = pc_write_s   & Reset_L;
  assign IRWrite    = ir_write_s   & Reset_L;
  assign RegWrite   = reg_write_s  & Reset_L;
  assign MemRead    = mem_read_s   & Reset_L;
  assign MemWrite   = mem_write_s  & Reset_L;
  assign IorD       = iord_s       & Reset_L;
  assign RegDst     = reg_dst_s    & Reset_L;
  assign MemToReg   = mem_to_reg_s & Reset_L;
  assign SignExtend = sign_ext_s   & Reset_L;
  assign InstrDone  = instr_done_s & Reset_L;
  assign ALUSrcA    = alu_src_a_s  & {2{Reset_L}};
  assign ALUSrcB    = alu_src_b_s  & {2{Reset_L}};
  assign ALUOp      = alu_op_s     & {4{Reset_L}};
  assign PCSource   = pc_source_s  & {2{Reset_L}};
  assign State      = state_r;
  assign Fault      = fault_r;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Testbench for multicycle_sequencer: directed steps for reset, timing,
// stall, timeout and illegal-opcode behaviour, followed by random
// instructions with random memory latency checked against a per-instruction
// reference model (cycle count, strobe counts, EXEC-cycle selects).
module tb_multicycle_sequencer;

  localparam int TIMEOUT = 15;

  localparam logic [5:0] OP_R     = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_XORI  = 6'b001110;

  logic       CLK = 1'b0;
  logic       Reset_L;
  logic [5:0] Opcode, FuncCode;
  logic       Zero, MemReady, Stall;
  logic       PCWrite, IRWrite, RegWrite, MemRead, MemWrite, IorD;
  logic       RegDst, MemToReg, SignExtend, InstrDone, Fault;
  logic [1:0] ALUSrcA, ALUSrcB, PCSource;
  logic [3:0] ALUOp;
  logic [2:0] State;

  multicycle_sequencer #(.TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .Reset_L(Reset_L), .Opcode(Opcode), .FuncCode(FuncCode),
    .Zero(Zero), .MemReady(MemReady), .Stall(Stall),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .MemRead(MemRead), .MemWrite(MemWrite), .IorD(IorD), .RegDst(RegDst),
    .MemToReg(MemToReg), .SignExtend(SignExtend), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource), .State(State),
    .InstrDone(InstrDone), .Fault(Fault)
  );

  always #5 CLK = ~CLK;

  logic [9:0] strobes;
  assign strobes = {PCWrite, IRWrite, RegWrite, MemRead, MemWrite, IorD,
                    RegDst, MemToReg, SignExtend, InstrDone};

  int checks = 0;
  int failures = 0;

  // Observations gathered by run_instr.
  int         st_cyc, st_regw, st_memw, st_pcw, st_irw, st_rd, st_m2r, st_done;
  logic [10:0] ex_vec;
  logic        ex_pcw;
  logic [2:0]  ex_state;
  bit          mem_tied = 1'b0;

  logic [5:0] legal_ops [12] = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ORI,
                                 OP_ADDI, OP_ADDIU, OP_ANDI, OP_LUI,
                                 OP_SLTI, OP_SLTIU};
  logic [5:0] fn_pool [5] = '{6'b000000, 6'b000010, 6'b000011, 6'b100000,
                             6'b100010};

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  // Reference: cycles per instruction from the class and memory waits.
  function automatic int ref_cpi(input logic [5:0] op, input int wf, input int wm);
    case (op)
      OP_J:    return 2 + wf;
      OP_BEQ:  return 3 + wf;
      OP_LW:   return 5 + wf + wm;
      OP_SW:   return 4 + wf + wm;
      default: return 4 + wf;
    endcase
  endfunction

  // Reference: {ALUOp, SignExtend, ALUSrcA, ALUSrcB, PCSource} in EXEC.
  function automatic logic [10:0] ref_exec(input logic [5:0] op, input logic [5:0] fn);
    logic [3:0] aop;
    logic       sx;
    logic [1:0] sa, sb, ps;
    aop = 4'b0010; sx = 1'b0; sa = 2'd1; sb = 2'd2; ps = 2'd0;
    case (op)
      OP_R: begin
        aop = 4'b1111; sb = 2'd0;
        sa = (fn == 6'd0 || fn == 6'd2 || fn == 6'd3) ? 2'd2 : 2'd1;
      end
      OP_BEQ:   begin aop = 4'b1010; sb = 2'd0; ps = 2'd1; end
      OP_LW, OP_SW, OP_ADDI: begin aop = 4'b0010; sx = 1'b1; end
      OP_ADDIU: begin aop = 4'b1000; sx = 1'b1; end
      OP_SLTI:  begin aop = 4'b0111; sx = 1'b1; end
      OP_SLTIU: begin aop = 4'b1011; sx = 1'b1; end
      OP_ANDI:  aop = 4'b0000;
      OP_ORI:   aop = 4'b0001;
      OP_XORI:  aop = 4'b1010;
      OP_LUI:   aop = 4'b1110;
      default:  aop = 4'b0000;
    endcase
    return {aop, sx, sa, sb, ps};
  endfunction

  // Run one instruction from FETCH; the memory answers after wf (fetch) or
  // wm (data) unanswered request cycles, or immediately when mem_tied.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                           input logic z, input int wf, input int wm);
    int fw, mw;
    bit done;
    Opcode = op; FuncCode = fn; Zero = z; Stall = 1'b0;
    fw = 0; mw = 0; done = 1'b0;
    st_cyc = 0; st_regw = 0; st_memw = 0; st_pcw = 0; st_irw = 0;
    st_rd = 0; st_m2r = 0; st_done = 0;
    ex_vec = '0; ex_pcw = 1'b0; ex_state = 3'd0;
    while (!done && st_cyc < 200) begin
      MemReady = 1'b0;
      #1;
      if (mem_tied) begin
        MemReady = 1'b1;
      end else if (MemRead || MemWrite) begin
        if (!IorD) begin MemReady = (fw >= wf); fw++; end
        else begin MemReady = (mw >= wm); mw++; end
      end
      #1;
      if (st_cyc == 2 + wf) begin
        ex_vec   = {ALUOp, SignExtend, ALUSrcA, ALUSrcB, PCSource};
        ex_pcw   = PCWrite;
        ex_state = State;
      end
      st_regw += int'(RegWrite);
      st_memw += int'(MemWrite);
      st_pcw  += int'(PCWrite);
      st_irw  += int'(IRWrite);
      st_rd   += int'(RegDst);
      st_m2r  += int'(MemToReg);
      if (InstrDone) done = 1'b1;
      st_cyc++;
      next_cycle();
      if (Fault) break;
    end
    MemReady = 1'b0;
    st_done = done ? 1 : 0;
  endtask

  task automatic reset_pulse();
    Reset_L = 1'b0;
    #1;
    chk("rstp_state", 32'(State), 32'd0);
    chk("rstp_fault", 32'(Fault), 32'd0);
    chk("rstp_strobes", 32'(strobes), 32'd0);
    next_cycle();
    Reset_L = 1'b1;
    #1;
  endtask

  initial begin
    int total;
    logic [5:0] op, fn;
    logic z;
    int wf, wm;

    Reset_L = 1'b0; Opcode = 6'd0; FuncCode = 6'd0; Zero = 1'b0;
    MemReady = 1'b0; Stall = 1'b0;

    // Reset state
    #2;
    chk("reset_state", 32'(State), 32'd0);
    chk("reset_fault", 32'(Fault), 32'd0);
    chk("reset_strobes", 32'(strobes), 32'd0);
    chk("reset_aluop", 32'(ALUOp), 32'd0);
    next_cycle();
    Reset_L = 1'b1;
    #1;
    chk("fetch_memread", 32'(MemRead), 32'd1);
    chk("fetch_selects", 32'({IorD, ALUSrcA, ALUSrcB, ALUOp, PCSource}),
        32'({1'b0, 2'd0, 2'd1, 4'b0010, 2'd0}));

    // Zero-wait program: ADDI, ADD, LW, SW
    mem_tied = 1'b1;
    total = 0;
    run_instr(OP_ADDI, 6'b100000, 1'b0, 0, 0);
    total += st_cyc;
    chk("tp_addi_done_cycle", 32'(total), 32'd4);
    chk("tp_addi_regdst", 32'(st_rd), 32'd0);
    run_instr(OP_R, 6'b100000, 1'b0, 0, 0);
    total += st_cyc;
    chk("tp_add_done_cycle", 32'(total), 32'd8);
    chk("tp_add_regdst", 32'(st_rd), 32'd1);
    chk("tp_add_memtoreg", 32'(st_m2r), 32'd0);
    run_instr(OP_LW, 6'b000000, 1'b0, 0, 0);
    total += st_cyc;
    chk("tp_lw_done_cycle", 32'(total), 32'd13);
    chk("tp_lw_memtoreg", 32'(st_m2r), 32'd1);
    chk("tp_lw_regdst", 32'(st_rd), 32'd0);
    run_instr(OP_SW, 6'b000000, 1'b0, 0, 0);
    total += st_cyc;
    chk("tp_sw_done_cycle", 32'(total), 32'd17);
    chk("tp_sw_memtoreg", 32'(st_m2r), 32'd0);
    mem_tied = 1'b0;

    // BEQ taken / not taken
    run_instr(OP_BEQ, 6'd0, 1'b1, 0, 0);
    chk("beq_t_cpi", 32'(st_cyc), 32'd3);
    chk("beq_t_pcwrite", 32'(ex_pcw), 32'd1);
    chk("beq_t_pcsource", 32'(ex_vec[1:0]), 32'd1);
    run_instr(OP_BEQ, 6'd0, 1'b0, 0, 0);
    chk("beq_nt_cpi", 32'(st_cyc), 32'd3);
    chk("beq_nt_pcwrite", 32'(ex_pcw), 32'd0);
    chk("beq_nt_pcw_total", 32'(st_pcw), 32'd1);

    // Shift operand select
    for (int i = 0; i < 4; i++) begin
      run_instr(OP_R, fn_pool[i], 1'b0, 0, 0);
      chk("shift_srca", 32'(ex_vec[5:4]), (i < 3) ? 32'd2 : 32'd1);
    end

    // LW with 3 wait cycles on the data access
    run_instr(OP_LW, 6'd0, 1'b0, 0, 3);
    chk("lw_wait3_cpi", 32'(st_cyc), 32'd8);

    // MemReady arriving when the counter reaches TIMEOUT: no fault
    run_instr(OP_ADDI, 6'd0, 1'b0, TIMEOUT, 0);
    chk("wait15_cpi", 32'(st_cyc), 32'(4 + TIMEOUT));
    chk("wait15_done", 32'(st_done), 32'd1);
    chk("wait15_nofault", 32'(Fault), 32'd0);

    // MemReady never arrives: fault
    Opcode = OP_LW; MemReady = 1'b0;
    for (int k = 0; k <= TIMEOUT; k++) begin
      #1;
      if (k == TIMEOUT) begin
        chk("to_state_edge", 32'(State), 32'd0);
        chk("to_memread_edge", 32'(MemRead), 32'd1);
        chk("to_fault_edge", 32'(Fault), 32'd0);
      end
      next_cycle();
    end
    #1;
    chk("to_state", 32'(State), 32'd7);
    chk("to_fault", 32'(Fault), 32'd1);
    chk("to_strobes", 32'(strobes), 32'd0);
    reset_pulse();

    // Illegal opcode
    Opcode = 6'b111111; MemReady = 1'b1;
    #1;
    chk("ill_fetch", 32'(MemRead), 32'd1);
    next_cycle();
    MemReady = 1'b0;
    #1;
    chk("ill_decode", 32'(State), 32'd1);
    next_cycle();
    #1;
    chk("ill_state", 32'(State), 32'd7);
    chk("ill_fault", 32'(Fault), 32'd1);
    MemReady = 1'b1;
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      chk("halt_state", 32'(State), 32'd7);
      chk("halt_strobes", 32'(strobes), 32'd0);
      chk("halt_fault", 32'(Fault), 32'd1);
    end
    MemReady = 1'b0;
    reset_pulse();
    chk("ill_clr_state", 32'(State), 32'd0);
    chk("ill_clr_memread", 32'(MemRead), 32'd1);
    chk("ill_clr_fault", 32'(Fault), 32'd0);

    // Stall at instruction boundary
    Opcode = OP_ADDI; Stall = 1'b1; MemReady = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("stall_memread", 32'(MemRead), 32'd0);
      chk("stall_pcwrite", 32'(PCWrite), 32'd0);
      chk("stall_state", 32'(State), 32'd0);
      next_cycle();
    end
    Stall = 1'b0; MemReady = 1'b0;
    #1;
    chk("unstall_memread", 32'(MemRead), 32'd1);
    next_cycle();
    Stall = 1'b1;
    #1;
    chk("midfetch_stall_memread", 32'(MemRead), 32'd1);
    MemReady = 1'b1;
    #1;
    chk("midfetch_irwrite", 32'(IRWrite), 32'd1);
    next_cycle();
    MemReady = 1'b0;
    #1;
    chk("stall_decode", 32'(State), 32'd1);
    next_cycle();
    chk("stall_exec", 32'(State), 32'd2);
    next_cycle();
    chk("stall_wb_done", 32'(InstrDone), 32'd1);
    chk("stall_wb_regwrite", 32'(RegWrite), 32'd1);
    next_cycle();
    chk("stall_boundary_memread", 32'(MemRead), 32'd0);

    // Reset dropped during SW MEM
    Stall = 1'b0; Opcode = OP_SW; MemReady = 1'b1;
    #1;
    next_cycle();
    MemReady = 1'b0;
    next_cycle();
    next_cycle();
    chk("sw_mem_state", 32'(State), 32'd3);
    chk("sw_mem_write", 32'({MemWrite, IorD}), 32'd3);
    next_cycle();
    chk("sw_mem_hold", 32'(MemWrite), 32'd1);
    Reset_L = 1'b0;
    #1;
    chk("sw_rst_memwrite", 32'(MemWrite), 32'd0);
    chk("sw_rst_state", 32'(State), 32'd0);
    chk("sw_rst_done", 32'(InstrDone), 32'd0);
    next_cycle();
    Reset_L = 1'b1;
    #1;

    // Random instructions against the reference model
    for (int n = 0; n < 30; n++) begin
      op = legal_ops[$urandom_range(0, 11)];
      fn = ($urandom_range(0, 1) == 0) ? fn_pool[$urandom_range(0, 4)]
                                        : 6'($urandom_range(0, 63));
      z  = 1'($urandom_range(0, 1));
      wf = $urandom_range(0, 3);
      wm = $urandom_range(0, 3);
      run_instr(op, fn, z, wf, wm);
      chk("rnd_cpi", 32'(st_cyc), 32'(ref_cpi(op, wf, wm)));
      chk("rnd_done", 32'(st_done), 32'd1);
      chk("rnd_fault", 32'(Fault), 32'd0);
      chk("rnd_regwrite", 32'(st_regw),
          (op == OP_J || op == OP_BEQ || op == OP_SW) ? 32'd0 : 32'd1);
      chk("rnd_memwrite", 32'(st_memw), (op == OP_SW) ? 32'(wm + 1) : 32'd0);
      chk("rnd_pcwrite", 32'(st_pcw),
          32'(1 + ((op == OP_J) ? 1 : 0) + ((op == OP_BEQ && z) ? 1 : 0)));
      chk("rnd_irwrite", 32'(st_irw), 32'd1);
      chk("rnd_regdst", 32'(st_rd), (op == OP_R) ? 32'd1 : 32'd0);
      chk("rnd_memtoreg", 32'(st_m2r), (op == OP_LW) ? 32'd1 : 32'd0);
      if (op != OP_J) begin
        chk("rnd_exec_state", 32'(ex_state), 32'd2);
        chk("rnd_exec_selects", 32'(ex_vec), 32'(ref_exec(op, fn)));
        chk("rnd_exec_pcwrite", 32'(ex_pcw), (op == OP_BEQ) ? 32'(z) : 32'd0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
